// File: rtl/sel_debounce_toggle.sv
// Button conditioner: 2-flop synchronizer, debounce counter and press FSM toggling sel.
// Define SEL_LONG_PRESS_EN to build the long-press detector (forces sel to 0, strobes long_pulse).
module sel_debounce_toggle #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic sel,
    output logic toggle_pulse,
    output logic long_pulse
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("sel_debounce_toggle: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic             s1;
    logic             btn_sync;
    logic             btn_stable;
    logic [CNT_W-1:0] cnt;
    logic             commit;
    logic             rise;
    logic             fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= 1'b0;
            btn_sync   <= 1'b0;
            btn_stable <= 1'b0;
            cnt        <= '0;
        end else begin
            s1       <= btn_in;
            btn_sync <= s1;
            if (btn_sync == btn_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_stable <= btn_sync;
                cnt        <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Commit events coincide with the edge on which btn_stable flips.
    assign commit = (btn_sync != btn_stable) && (cnt == CNT_LAST);
    assign rise   = commit && btn_sync;
    assign fall   = commit && !btn_sync;

`ifdef SEL_LONG_PRESS_EN
    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
    localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              long_nxt;
`else
    typedef enum logic {IDLE, HELD} state_t;
`endif

    state_t state;
    state_t state_nxt;
    logic   sel_nxt;
    logic   toggle_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sel          <= 1'b0;
            toggle_pulse <= 1'b0;
`ifdef SEL_LONG_PRESS_EN
            long_pulse   <= 1'b0;
            hold_cnt     <= '0;
`endif
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            toggle_pulse <= toggle_nxt;
`ifdef SEL_LONG_PRESS_EN
            long_pulse   <= long_nxt;
            hold_cnt     <= hold_cnt_nxt;
`endif
        end
    end

`ifndef SEL_LONG_PRESS_EN
    assign long_pulse = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        toggle_nxt = 1'b0;
`ifdef SEL_LONG_PRESS_EN
        long_nxt     = 1'b0;
        hold_cnt_nxt = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    sel_nxt    = !sel;
                    toggle_nxt = 1'b1;
                    state_nxt  = HELD;
`ifdef SEL_LONG_PRESS_EN
                    hold_cnt_nxt = '0;
`endif
                end
            end
            HELD: begin
`ifdef SEL_LONG_PRESS_EN
                if (hold_cnt != '1) begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
`endif
                // A fall on the same edge as the long-count hit takes priority.
                if (fall) begin
                    state_nxt = IDLE;
                end
`ifdef SEL_LONG_PRESS_EN
                else if (hold_cnt == HOLD_LAST) begin
                    sel_nxt    = 1'b0;
                    toggle_nxt = sel;
                    long_nxt   = 1'b1;
                    state_nxt  = LONG;
                end
`endif
            end
`ifdef SEL_LONG_PRESS_EN
            LONG: begin
                if (fall) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sel_debounce_toggle.sv
// Randomized bench for sel_debounce_toggle against a history-based reference model.
// Follows SEL_LONG_PRESS_EN the same way the design does.
module tb_sel_debounce_toggle;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b0;
    logic sel;
    logic toggle_pulse;
    logic long_pulse;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    sel_debounce_toggle #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .sel         (sel),
        .toggle_pulse(toggle_pulse),
        .long_pulse  (long_pulse)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic pipe[$];
    logic seen[$];
    logic m_stable = 1'b0;
    logic m_sel    = 1'b0;
    logic m_toggle = 1'b0;
    logic m_long   = 1'b0;
    logic armed    = 1'b0;
    int   cyc      = 0;
    int   press_edge = 0;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic sync_v;
        logic commit;
        logic rise;
        logic fall;
        cyc++;
        m_toggle = 1'b0;
        m_long   = 1'b0;
        if (r) begin
            m_sel    = 1'b0;
            m_stable = 1'b0;
            armed    = 1'b0;
            pipe     = '{1'b0, 1'b0};
            seen.delete();
            return;
        end
        sync_v = pipe[0];
        void'(pipe.pop_front());
        pipe.push_back(b);
        seen.push_back(sync_v);
        if (seen.size() > DEB) void'(seen.pop_front());
        // Accept a new level once the last DEB synced samples all disagree with the stable one.
        commit = (seen.size() == DEB);
        foreach (seen[i]) if (seen[i] == m_stable) commit = 1'b0;
        rise = commit && !m_stable;
        fall = commit && m_stable;
        if (commit) m_stable = !m_stable;
        if (rise) begin
            m_sel      = !m_sel;
            m_toggle   = 1'b1;
            press_edge = cyc;
            armed      = 1'b1;
        end else if (fall) begin
            armed = 1'b0;
        end
`ifdef SEL_LONG_PRESS_EN
        else if (armed && cyc == press_edge + int'(LONG)) begin
            m_long   = 1'b1;
            m_toggle = m_sel;
            m_sel    = 1'b0;
            armed    = 1'b0;
        end
`endif
    endtask

    task automatic step(input logic b, input logic r);
        btn_in = b;
        reset  = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        check_eq("sel", sel, m_sel);
        check_eq("toggle_pulse", toggle_pulse, m_toggle);
        check_eq("long_pulse", long_pulse, m_long);
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        pipe = '{1'b0, 1'b0};
        // Reset held with the button pressed
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        hold(1'b0, 6);
        // Clean press, release, press again
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 10);
        // Bounce then settle high
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
        hold(1'b1, 10);
        hold(1'b0, 10);
        // Glitches just shorter than the debounce window
        hold(1'b1, 3);
        hold(1'b0, 10);
        hold(1'b1, 3);
        hold(1'b0, 1);
        hold(1'b1, 3);
        hold(1'b0, 10);
        // Long hold from sel=0 (toggles to 1 first)
        if (m_sel) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        hold(1'b1, 30);
        hold(1'b0, 12);
        // Long hold from sel=1 if reachable, then release exactly at the long boundary region
        hold(1'b1, 26);
        hold(1'b0, 10);
        for (int l = 22; l <= 27; l++) begin
            hold(1'b1, l);
            hold(1'b0, 10);
        end
        // Reset mid-hold at cycle 8 of a press, button kept high
        hold(1'b1, 8);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        hold(1'b1, 12);
        hold(1'b0, 10);
        // Random segments
        for (int s = 0; s < 160; s++) begin
            int unsigned len;
            logic lvl;
            if ($urandom_range(0, 29) == 0) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < int'(len); i++) step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                lvl = 1'($urandom_range(0, 1));
                len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : $urandom_range(4, 30);
                hold(lvl, int'(len));
            end
        end
        hold(1'b0, 10);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sel_debounce_toggle.md
# sel_debounce_toggle

Upstream stage for the stream LED top. It conditions the raw push-button (or slide switch) that selects between the two LED patterns and produces a clean, registered `sel` level. The block provides a 2-flop synchronizer, a consecutive-cycle debounce counter, and a press-state FSM that toggles `sel` once per debounced press. It runs on the board clock `clk`, not on the divided LED clock.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- `LONG_CYCLES`, default 100000000: held-press duration for long-press detection (1 s at 100 MHz); must be greater than `DEBOUNCE_CYCLES`.
- `clk`, input, 1: board clock.
- `reset`, input, 1: synchronous, active-high reset.
- `btn_in`, input, 1: raw asynchronous button level; 1 = pressed.
- `sel`, output, 1: registered pattern select; feeds the pattern switch.
- `toggle_pulse`, output, 1: one-cycle strobe on every `sel` change.
- `long_pulse`, output, 1: one-cycle strobe on long press; tied 0 when the long-press feature is compiled out.

## Operation
- Synchronizer: `btn_in` → `s1` → `btn_sync`, two flops. Both flops reset to 0.
- Debounce: `btn_stable` (reset 0) and `cnt` (reset 0). The width of `cnt` is sized to hold `DEBOUNCE_CYCLES-1`.
  - If `btn_sync == btn_stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `btn_stable <= btn_sync`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any single-cycle return to the stable level restarts the count from 0. Glitches shorter than `DEBOUNCE_CYCLES` are never accepted.
- Press FSM (state reset = IDLE). It is advanced by the commit events `rise` and `fall`, which occur on the edge where `btn_stable` changes.
  - IDLE: on `rise`, toggle `sel`, set `toggle_pulse`, clear `hold_cnt`, and go to HELD.
  - HELD: increment `hold_cnt`.
    - On `fall`, go to IDLE.
    - With the feature compiled in: when `hold_cnt == LONG_CYCLES-1` and no `fall` occurs, force `sel <= 0`, set `long_pulse`, and go to LONG. `toggle_pulse` is also set if `sel` was 1.
  - LONG: `hold_cnt` is frozen. On `fall`, go to IDLE. No other effect.
  - Same-edge `fall` and long-count hit in HELD: `fall` wins and no long press is registered.
- Reset values: `sel`=0, `toggle_pulse`=0, `long_pulse`=0, state=IDLE, `hold_cnt`=0, `cnt`=0, `btn_stable`=0.
- Reset mid-press: everything returns to the reset values. A button still held after reset release must first be debounced as a new `rise` (`btn_stable` is 0 again) and toggles `sel` to 1.
- `hold_cnt` saturates; it never wraps.

## Timing
- `btn_in` change before edge E0 → `btn_sync` updates after E1.
  - `btn_stable`, `sel`, and the FSM update on edge E(1+`DEBOUNCE_CYCLES`).
  - End-to-end latency: `DEBOUNCE_CYCLES`+1 to `DEBOUNCE_CYCLES`+2 cycles, depending on input phase.
- `toggle_pulse` and `long_pulse` are registered. Each is high for exactly the one cycle following the edge on which `sel` changes or the long press fires.
- Long press fires `LONG_CYCLES` cycles after the `rise` commit edge.
- All outputs are glitch-free flop outputs. There is no combinational path from `btn_in`.

## Configuration
- `SEL_LONG_PRESS_EN` defined:
  - `hold_cnt` and the LONG state are built.
  - A held press of ≥ `LONG_CYCLES` forces `sel` to 0 (pattern 1) and strobes `long_pulse`.
- Not defined:
  - No `hold_cnt`; the FSM has only IDLE/HELD.
  - `long_pulse` is constant 0.
  - Holding has no effect beyond the initial toggle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=20.
- Reset held 3 cycles with `btn_in`=1 → `sel`=0, both pulses 0 throughout reset.
- Clean press: `btn_in` 0→1 held 10 cycles → `sel` 0→1 exactly once, 5–6 cycles after the change; `toggle_pulse` high for 1 cycle. Release and press again → `sel`=0.
- Bounce: `btn_in` toggles 1,0,1,0 each cycle, then holds 1 → no `sel` change until 4 stable synced cycles; exactly one `toggle_pulse`.
- Glitch: a 3-cycle high pulse on `btn_in` → `sel` unchanged, no pulses.
- Long press (macro on): hold 30 cycles from `sel`=0 → `sel` goes 1, then 0 exactly 20 cycles after the `rise` commit; one `long_pulse`; release produces no further change. With the macro off: `sel` stays 1 and `long_pulse` stays 0.
- Reset mid-hold at cycle 8 of a press, `btn_in` kept 1 → after reset, `sel` is 0, then goes to 1 after 4 synced stable cycles.
